multimode_ring_counter: RTL
===========================

Name: multimode_ring_counter

Overview:
Parametrised N-bit shift-register counter with two modes: one-hot ring (period N) and Johnson/twisted-ring (period 2N).
It adds run-time direction control, count enable, parallel load, a wrap pulse, illegal-state detection and optional self-correction.
It serves as the sequencing and one-hot-select generator for downstream control blocks, replacing fixed-width single-mode ring counters.

Parameters:
N, 4, counter width in bits; legal values N >= 2
SELF_CORRECT, 1, 1 = an enabled step from an illegal state reloads the mode seed; 0 = shift illegal states unchanged

Ports:
clk  input  1  clock, all state on rising edge
rstn  input  1  reset, synchronous, active-low
en  input  1  step enable
mode  input  1  0 = ring, 1 = Johnson
dir  input  1  0 = shift toward bit 0 (right), 1 = shift toward bit N-1 (left)
load  input  1  parallel load strobe
load_val  input  N  value written on load
out  output  N  counter state
wrap  output  1  registered one-cycle pulse: an enabled step has just returned out to the seed
illegal  output  1  combinational: out is not a legal state for the current mode

Behaviour:
- Clocking and reset: clk and rstn are the already-decided clock and reset (synchronous, active-low).
- Seeds:
  - Ring seed: 0…01.
  - Johnson seed: 0…0.
- Reset (rstn=0 at a clock edge):
  - out <= seed of the current mode; wrap <= 0; mode_q <= mode.
  - Reset overrides all other inputs, including mid-count.
- Priority per edge: reset > load > mode change > step (en=1) > hold.
- Load:
  - out <= load_val (any value, including illegal); wrap <= 0.
  - load wins over en in the same cycle.
- Mode change:
  - Internal register mode_q tracks the last sampled mode.
  - If mode != mode_q and load=0: out <= seed of the new mode, wrap <= 0, mode_q <= mode.
  - This applies regardless of en.
- Step, ring mode:
  - dir=0: out <= {out[0], out[N-1:1]}.
  - dir=1: out <= {out[N-2:0], out[N-1]}.
- Step, Johnson mode:
  - dir=0: out <= {~out[0], out[N-1:1]}.
  - dir=1: out <= {out[N-2:0], ~out[N-1]}.
- Direction: dir may change on any cycle; the next step uses the new direction immediately, with no reseed.
- Hold: en=0 and no other event: out and mode_q unchanged; wrap <= 0.
- wrap: set to 1 exactly on an edge where a step (not load, reset, reseed or self-correct) produces out == seed; otherwise 0.
- illegal, from current out and mode_q:
  - Ring: popcount(out) != 1.
  - Johnson: the number of positions i in [0,N-2] with out[i] != out[i+1] is greater than 1.
  - Legal Johnson states are exactly 0^a1^b and 1^a0^b.
- Self-correction (SELF_CORRECT=1):
  - A step taken while illegal=1 gives out <= seed, wrap <= 0.
  - With SELF_CORRECT=0, the step shifts normally and the illegal state may persist indefinitely.
- Latency: one clock from any control input to out; illegal follows out combinationally in the same cycle.

Decomposition:
- Package ring_cnt_pkg:
  - mode constants MODE_RING=1'b0, MODE_JOHNSON=1'b1
  - dir constants DIR_RIGHT=1'b0, DIR_LEFT=1'b1
  - function seed(mode, N)
- Sub-module ring_state_checker (parameter N; inputs state and mode; output illegal): purely combinational legality decode, reused by other sequencer blocks.
- Top level holds the out, mode_q and wrap registers and the next-state mux.

Test Plan:
1. N=4, reset, mode=0, dir=0, en=1 for 4 cycles -> out 0001, 1000, 0100, 0010, 0001; wrap=1 only in the cycle out returns to 0001.
2. mode=1 after reset, dir=0, en=1 for 8 cycles -> 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000; wrap pulses once at the 8th step; illegal=0 throughout.
3. Ring mode, dir=1, en=1 -> 0001, 0010, 0100, 1000, 0001. Then flip dir to 0 at 0100 -> next value 0010, no reseed.
4. load=1, load_val=0101, mode=0 -> out=0101, illegal=1.
   - Next cycle en=1, SELF_CORRECT=1 -> out=0001, illegal=0, wrap=0.
   - Same stimulus with SELF_CORRECT=0 -> out=1010, illegal=1.
5. Ring count at 0100, then mode 0->1 with en=0 -> out=0000 next edge.
   - Hold en=0 three cycles -> out stays 0000.
   - rstn=0 mid-count at 1100 -> out=0000 (Johnson seed), wrap=0.
6. load=1 and en=1 together, load_val=0010 -> out=0010, no step applied.
   - load and mode change together -> load value wins; mode_q updates on the following cycle, giving a reseed.

Source files
------------

// File: rtl/ring_cnt_pkg.sv
// Shared mode/direction encodings and seed values for ring and Johnson sequencers.
package ring_cnt_pkg;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  // Returned wide so any counter up to 64 bits can size-cast it to its own width.
  function automatic logic [63:0] seed(input logic mode, input int n);
    seed = '0;
    if (mode == MODE_RING && n > 0) seed[0] = 1'b1;
  endfunction

endpackage

// File: rtl/ring_state_checker.sv
// Combinational legality decode for ring (one-hot) and Johnson (0^a1^b / 1^a0^b) states.
module ring_state_checker
  import ring_cnt_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] state,
  input  logic         mode,
  output logic         illegal
);

  logic [N-2:0] edges;

  // A legal Johnson word has at most one boundary between adjacent bits.
  assign edges = state[N-2:0] ^ state[N-1:1];

  always_comb begin
    if (mode == MODE_RING) illegal = ($countones(state) != 1);
    else                   illegal = ($countones(edges) > 1);
  end

endmodule

// File: rtl/multimode_ring_counter.sv
// Ring / Johnson shift counter with direction, load, wrap pulse and optional self-correction.
// One clock from any control input to out; illegal is combinational from out; no backpressure.
module multimode_ring_counter
  import ring_cnt_pkg::*;
#(
  parameter int N            = 4,
  parameter bit SELF_CORRECT = 1'b1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic         mode,
  input  logic         dir,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] out,
  output logic         wrap,
  output logic         illegal
);

  logic [N-1:0] out_q, out_d;
  logic         mode_q, mode_d;
  logic         wrap_q, wrap_d;
  logic [N-1:0] seed_new, seed_cur, shifted;
  logic         feed_r, feed_l;
  logic         illegal_w;

  assign seed_new = N'(seed(mode, N));
  assign seed_cur = N'(seed(mode_q, N));

  // Johnson mode inverts the bit wrapping around the end of the register.
  assign feed_r  = out_q[0]   ^ (mode_q == MODE_JOHNSON);
  assign feed_l  = out_q[N-1] ^ (mode_q == MODE_JOHNSON);
  assign shifted = (dir == DIR_LEFT) ? {out_q[N-2:0], feed_l} : {feed_r, out_q[N-1:1]};

  ring_state_checker #(.N(N)) u_checker (
    .state   (out_q),
    .mode    (mode_q),
    .illegal (illegal_w)
  );

  always_comb begin
    out_d  = out_q;
    mode_d = mode_q;
    wrap_d = 1'b0;
    if (!rstn) begin
      out_d  = seed_new;
      mode_d = mode;
    end else if (load) begin
      // mode_q is left alone so a simultaneous mode change reseeds next cycle.
      out_d = load_val;
    end else if (mode != mode_q) begin
      out_d  = seed_new;
      mode_d = mode;
    end else if (en) begin
      if (SELF_CORRECT && illegal_w) begin
        out_d = seed_cur;
      end else begin
        out_d  = shifted;
        wrap_d = (shifted == seed_cur);
      end
    end
  end

  always_ff @(posedge clk) begin
    out_q  <= out_d;
    mode_q <= mode_d;
    wrap_q <= wrap_d;
  end

  assign out     = out_q;
  assign wrap    = wrap_q;
  assign illegal = illegal_w;

endmodule
